// File: rtl/lightbike_pkg.sv
// Shared encodings and defaults for the lightbike bike FSM.
package lightbike_pkg;

    // Bit 0 of the heading separates the vertical (1) and horizontal (0) axes,
    // and flipping bit 1 gives the reverse direction.
    typedef enum logic [1:0] {
        HD_RIGHT = 2'b00,
        HD_UP    = 2'b01,
        HD_LEFT  = 2'b10,
        HD_DOWN  = 2'b11
    } heading_e;

    // One-hot so the q_* flags are direct register bits.
    typedef enum logic [4:0] {
        ST_I         = 5'b00001,
        ST_STRAIGHT  = 5'b00010,
        ST_TURNING   = 5'b00100,
        ST_COLLISION = 5'b01000,
        ST_DONE      = 5'b10000
    } state_e;

    localparam int GRID_W_DEF  = 32;
    localparam int GRID_H_DEF  = 32;
    localparam int START_X_DEF = 2;
    localparam int START_Y_DEF = 16;

    // Filters out same/reverse requests (only perpendicular turns survive),
    // then picks Up > Down > Left > Right. Returns {valid, heading}.
    function automatic logic [2:0] pick_dir(input logic [3:0] req, input logic [1:0] hdg);
        logic [3:0] ok;
        ok = {req[3:2] & {2{~hdg[0]}}, req[1:0] & {2{hdg[0]}}};
        if (ok[3])      pick_dir = {1'b1, HD_UP};
        else if (ok[2]) pick_dir = {1'b1, HD_DOWN};
        else if (ok[1]) pick_dir = {1'b1, HD_LEFT};
        else if (ok[0]) pick_dir = {1'b1, HD_RIGHT};
        else            pick_dir = 3'b000;
    endfunction

endpackage

// File: rtl/lightbike_trail_mem.sv
// Trail bitmap: one bit per grid cell, clear-all, single-bit write, comb read.
module lightbike_trail_mem #(
    parameter int GRID_W = 32,
    parameter int GRID_H = 32,
    parameter int XW     = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    parameter int YW     = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          rd_bit
);

    logic [GRID_H-1:0][GRID_W-1:0] mem_q, mem_d;

    // Clear happens first so a clear and a write in the same cycle leave
    // exactly the written cell set.
    always_comb begin
        mem_d = mem_q;
        if (clr) mem_d = '0;
        if (we)  mem_d[wr_y][wr_x] = 1'b1;
    end

    // Bitmap register with synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign rd_bit = mem_q[rd_y][rd_x];

endmodule

// File: rtl/lightbike_bike_fsm.sv
// Single lightbike: position, heading, move count and trail collision FSM.
module lightbike_bike_fsm
    import lightbike_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int START_X = START_X_DEF,
    parameter int START_Y = START_Y_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Step,
    input  logic [3:0] Dir_Req,
    output logic [4:0] X,
    output logic [4:0] Y,
    output logic [1:0] Heading,
    output logic [7:0] Move_Count,
    output logic       q_I,
    output logic       q_Straight,
    output logic       q_Turning,
    output logic       q_Collision,
    output logic       q_Done
);

    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam logic [4:0] SX = 5'(START_X);
    localparam logic [4:0] SY = 5'(START_Y);

    state_e     state_q, state_d;
    logic [4:0] x_q, x_d, y_q, y_d;
    heading_e   hdg_q, hdg_d, turn_q, turn_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;

    logic [5:0]    nx, ny;
    logic          oob, hit, mv, dv;
    logic [2:0]    pick;
    heading_e      dh;
    logic          mem_clr, mem_we, rd_bit;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;

    // Candidate next cell; one extra bit so stepping off either edge is visible
    // (0 - 1 wraps to 63, which is always >= the grid size).
    always_comb begin
        nx = {1'b0, x_q};
        ny = {1'b0, y_q};
        case (hdg_q)
            HD_RIGHT: nx = {1'b0, x_q} + 6'd1;
            HD_LEFT:  nx = {1'b0, x_q} - 6'd1;
            HD_UP:    ny = {1'b0, y_q} - 6'd1;
            HD_DOWN:  ny = {1'b0, y_q} + 6'd1;
            default:  ;
        endcase
    end

    assign oob  = (nx >= 6'(GRID_W)) || (ny >= 6'(GRID_H));
    assign hit  = oob || rd_bit;
    assign pick = pick_dir(Dir_Req, hdg_q);
    assign dv   = pick[2];
    assign dh   = heading_e'(pick[1:0]);
    assign mv   = Step || pend_q;

    lightbike_trail_mem #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_trail (
        .clk    (Clk),
        .rst_n  (Reset),
        .clr    (mem_clr),
        .we     (mem_we),
        .wr_x   (wr_x),
        .wr_y   (wr_y),
        .rd_x   (nx[XW-1:0]),
        .rd_y   (ny[YW-1:0]),
        .rd_bit (rd_bit)
    );

    // Next-state, datapath updates and trail write control.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hdg_d   = hdg_q;
        turn_d  = turn_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mem_clr = 1'b0;
        mem_we  = 1'b0;
        wr_x    = nx[XW-1:0];
        wr_y    = ny[YW-1:0];
        case (state_q)
            ST_I: begin
                if (Start) begin
                    mem_clr = 1'b1;
                    mem_we  = 1'b1;
                    wr_x    = SX[XW-1:0];
                    wr_y    = SY[YW-1:0];
                    x_d     = SX;
                    y_d     = SY;
                    hdg_d   = HD_RIGHT;
                    cnt_d   = 8'd0;
                    pend_d  = 1'b0;
                    state_d = ST_STRAIGHT;
                end
            end
            ST_STRAIGHT: begin
                pend_d = 1'b0;
                if (mv && hit) begin
                    // Collision wins over any turn requested this cycle.
                    state_d = ST_COLLISION;
                end else begin
                    if (mv) begin
                        x_d    = nx[4:0];
                        y_d    = ny[4:0];
                        mem_we = 1'b1;
                        cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
                    if (dv) begin
                        turn_d  = dh;
                        state_d = ST_TURNING;
                    end
                end
            end
            ST_TURNING: begin
                hdg_d   = turn_q;
                if (Step) pend_d = 1'b1;
                state_d = ST_STRAIGHT;
            end
            ST_COLLISION: state_d = ST_DONE;
            ST_DONE: begin
                if (Ack) state_d = ST_I;
            end
            default: state_d = ST_I;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_I;
            x_q     <= SX;
            y_q     <= SY;
            hdg_q   <= HD_RIGHT;
            turn_q  <= HD_RIGHT;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hdg_q   <= hdg_d;
            turn_q  <= turn_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign X           = x_q;
    assign Y           = y_q;
    assign Heading     = hdg_q;
    assign Move_Count  = cnt_q;
    assign q_I         = state_q[0];
    assign q_Straight  = state_q[1];
    assign q_Turning   = state_q[2];
    assign q_Collision = state_q[3];
    assign q_Done      = state_q[4];

endmodule

// File: doc/lightbike_bike_fsm.md
LIGHTBIKE_BIKE_FSM -- requirements
Module: lightbike_bike_fsm

Interface
REQ-001 Parameter GRID_W, default 32, grid width in cells (power of 2, max 32).
REQ-002 Parameter GRID_H, default 32, grid height in cells (power of 2, max 32).
REQ-003 Parameter START_X, default 2, start column.
REQ-004 Parameter START_Y, default 16, start row.
REQ-005 The port list SHALL be:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  single-cycle pulse; starts a round.
- Ack  in  1  single-cycle pulse; leaves Done.
- Step  in  1  single-cycle move tick (clock enable).
- Dir_Req  in  4  one-hot direction pulses {Up, Down, Left, Right}.
- X  out  5  bike column.
- Y  out  5  bike row.
- Heading  out  2  current heading.
- Move_Count  out  8  moves completed this round.
- q_I, q_Straight, q_Turning, q_Collision, q_Done  out  1 each  one-hot state flags.

Function
REQ-006 The FSM SHALL have exactly five states, I, STRAIGHT, TURNING, COLLISION and DONE; exactly one q_* flag is high in every cycle.
REQ-007 Heading encoding SHALL be 00 Right (+X), 01 Up (-Y), 10 Left (-X), 11 Down (+Y).
REQ-008 In I, on Start, the block SHALL clear the entire trail, set X=START_X, Y=START_Y, Heading=Right and Move_Count=0, mark the start cell, and enter STRAIGHT on the next clock.
REQ-009 In I, Step, Dir_Req and Ack SHALL be ignored.
REQ-010 In STRAIGHT, on Step, next = (X,Y) + heading delta.
- Next outside 0..GRID_W-1 or 0..GRID_H-1: collision (no wrap-around).
- Next trail bit already set: collision.
- Otherwise: X/Y update, next cell marked, Move_Count increments.
REQ-011 Move_Count SHALL saturate at 255.
REQ-012 On a collision, X/Y/Move_Count SHALL hold and the FSM SHALL enter COLLISION.
REQ-013 In STRAIGHT, a Dir_Req whose direction equals Heading or its reverse SHALL be ignored.
REQ-014 In STRAIGHT, any other Dir_Req SHALL latch the new heading and go to TURNING.
REQ-015 Multiple Dir_Req bits in one cycle SHALL resolve with priority Up > Down > Left > Right, evaluated after reverse/same filtering.
REQ-016 Step and a valid Dir_Req in the same STRAIGHT cycle: the move SHALL use the old heading, and the turn is latched.
- If that move collides, collision wins and the turn is discarded.
REQ-017 TURNING SHALL last exactly one cycle: Heading updates to the latched value, then the FSM returns to STRAIGHT.
REQ-018 A Step arriving in TURNING SHALL set a pending flag; the move executes in the first STRAIGHT cycle with the new heading.
REQ-019 Dir_Req in TURNING SHALL be ignored.
REQ-020 COLLISION SHALL last exactly one cycle, then the FSM enters DONE.
REQ-021 In DONE, outputs SHALL hold; on Ack the FSM returns to I, with X/Y/Heading/Move_Count retained until the next Start.
REQ-022 Start outside I SHALL be ignored.
REQ-023 All outputs SHALL be registered; X/Y reflect a move one clock after the Step.

Reset
REQ-024 When Reset=0 at a Clk edge, the block SHALL produce:
- State = I, q_I=1, other flags 0.
- X=START_X, Y=START_Y, Heading=00, Move_Count=0.
- Trail cleared, pending-step flag cleared.
REQ-025 Reset asserted mid-round SHALL abort the round with the same result; no partial move is committed.

Structure
REQ-026 Package lightbike_pkg SHALL hold the heading encodings, the state encoding and the default grid constants.
REQ-027 Trail storage SHALL be the sub-module lightbike_trail_mem:
- GRID_H words of GRID_W bits.
- Single-cycle clear-all, combinational read of a single bit, single-bit write.

Verification
REQ-028 Reset, Start, 5 Steps -> X=7, Y=16, Move_Count=5, q_Straight=1.
REQ-029 Start, 29 Steps, then 1 Step -> at the 30th Step X would be 32: q_Collision for one cycle then q_Done, X=31, Move_Count=29; Ack -> q_I.
REQ-030 Start, Step, then Dir_Req=Left -> ignored, Heading=00.
REQ-031 Start, Step, then Dir_Req=Up+Right in one cycle -> Up chosen: q_Turning one cycle, Heading=01.
REQ-032 Start, then Dir_Req=Up and Step in the same cycle:
- X=3, then TURNING.
- A Step during TURNING leaves Y=15 one clock after returning to STRAIGHT.
REQ-033 Start, moves forming a closed loop (R, D, L, U back onto own trail) -> collision on the revisited cell.
REQ-034 After REQ-033, Reset=0 mid-DONE, then Start -> Move_Count=0 and the trail is clear.
